// File: rtl/ysyx_25060170_lsu_wbu_pkg.sv
// Shared types for the LSU/WBU stage: FSM states, funct3 encodings, the latched
// instruction record and the registered output bundle.
package ysyx_25060170_lsu_wbu_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB
  } state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             rd_wen;
    logic             is_load;
    logic             is_store;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  result;
    logic [XLEN-1:0]  store_data;
  } op_t;

  typedef struct packed {
    logic             in_ready;
    logic             req_valid;
    logic             req_wen;
    logic [XLEN-1:0]  req_addr;
    logic [XLEN-1:0]  req_wdata;
    logic [3:0]       req_wmask;
    logic [REG_W-1:0] rf_waddr;
    logic [XLEN-1:0]  rf_wdata;
    logic             rf_wen;
    logic             commit;
    logic             commit_misalign;
  } out_t;

  localparam out_t OUT_RESET = '{in_ready: 1'b1, default: '0};

  // Any funct3 that is not a known byte/half encoding falls back to a word access.
  function automatic size_e access_size(input logic is_load, input logic [2:0] funct3);
    if (funct3 == F3_LB || (is_load && funct3 == F3_LBU)) return SZ_BYTE;
    if (funct3 == F3_LH || (is_load && funct3 == F3_LHU)) return SZ_HALF;
    return SZ_WORD;
  endfunction

endpackage

// File: rtl/ysyx_25060170_lsu_wbu_if.sv
// Memory port between the LSU/WBU stage (master) and the data memory (slave).
interface ysyx_25060170_lsu_wbu_if;
  import ysyx_25060170_lsu_wbu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            req_wen;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_wmask;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ysyx_25060170_lsu_align.sv
// Combinational byte-lane logic: store mask/data placement, load lane extract
// with sign/zero extension, and misalignment detection.
module ysyx_25060170_lsu_align
  import ysyx_25060170_lsu_wbu_pkg::*;
#(
  parameter int CHECK_ALIGN = 1
) (
  input  logic            is_load,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misalign
);

  size_e       size;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        is_unsigned;

  assign size        = access_size(is_load, funct3);
  assign byte_lane   = rdata[{offset, 3'b000} +: 8];
  assign half_lane   = offset[1] ? rdata[31:16] : rdata[15:0];
  assign is_unsigned = funct3[2];

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    wmask     = 4'hF;
    wdata     = store_data;
    load_data = rdata;
    misalign  = 1'b0;
    case (size)
      SZ_BYTE: begin
        wmask     = 4'b0001 << offset;
        wdata     = {4{store_data[7:0]}};
        load_data = is_unsigned ? {24'b0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      end
      SZ_HALF: begin
        wmask     = 4'b0011 << offset;
        wdata     = {2{store_data[15:0]}};
        load_data = is_unsigned ? {16'b0, half_lane} : {{16{half_lane[15]}}, half_lane};
        misalign  = (CHECK_ALIGN != 0) && offset[0];
      end
      default: begin
        misalign = (CHECK_ALIGN != 0) && (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/ysyx_25060170_lsu_wbu.sv
// Memory-access + writeback stage: accepts one instruction, performs its load/store,
// then drives the regfile write port and a one-cycle commit pulse.
module ysyx_25060170_lsu_wbu
  import ysyx_25060170_lsu_wbu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int RADDR_W     = 5,
  parameter int CHECK_ALIGN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic               in_rd_wen,
  input  logic               in_is_load,
  input  logic               in_is_store,
  input  logic [2:0]         in_funct3,
  input  logic [DATA_W-1:0]  in_result,
  input  logic [DATA_W-1:0]  in_store_data,
  ysyx_25060170_lsu_wbu_if.master mem,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               rf_wen,
  output logic               commit,
  output logic               commit_misalign
);

  state_e state, state_n;
  op_t    lat, lat_n, in_op, cur;
  out_t   out_q, out_n;

  logic [3:0]      al_wmask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_load;
  logic            al_misalign;
  logic            is_mem;
  logic            mis;

  assign in_op = '{rd: in_rd, rd_wen: in_rd_wen, is_load: in_is_load, is_store: in_is_store,
                   funct3: in_funct3, result: in_result, store_data: in_store_data};

  // In IDLE the aligner looks at the incoming op so misalign and store lanes are
  // known at the accept edge; afterwards it works on the latched copy.
  assign cur    = (state == S_IDLE) ? in_op : lat;
  assign is_mem = cur.is_load | cur.is_store;
  assign mis    = is_mem & al_misalign;

  ysyx_25060170_lsu_align #(
    .CHECK_ALIGN(CHECK_ALIGN)
  ) u_align (
    .is_load   (cur.is_load),
    .funct3    (cur.funct3),
    .offset    (cur.result[1:0]),
    .store_data(cur.store_data),
    .rdata     (mem.resp_rdata),
    .wmask     (al_wmask),
    .wdata     (al_wdata),
    .load_data (al_load),
    .misalign  (al_misalign)
  );

  // NOTE: sequential state uses non-blocking assignments only; next values come from always_comb.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      lat   <= '0;
      out_q <= OUT_RESET;
    end else begin
      state <= state_n;
      lat   <= lat_n;
      out_q <= out_n;
    end
  end

  always_comb begin
    state_n                = state;
    lat_n                  = lat;
    out_n                  = out_q;
    out_n.in_ready         = 1'b0;
    out_n.rf_wen           = 1'b0;
    out_n.commit           = 1'b0;
    out_n.commit_misalign  = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          lat_n = in_op;
          if (is_mem && !mis) begin
            state_n         = S_REQ;
            out_n.req_valid = 1'b1;
            out_n.req_addr  = {cur.result[31:2], 2'b00};
            out_n.req_wen   = cur.is_store;
            out_n.req_wdata = cur.is_store ? al_wdata : '0;
            out_n.req_wmask = cur.is_store ? al_wmask : 4'b0000;
          end else begin
            state_n               = S_WB;
            out_n.rf_waddr        = cur.rd;
            out_n.rf_wdata        = cur.result;
            out_n.rf_wen          = cur.rd_wen & ~cur.is_store & ~mis & (cur.rd != '0);
            out_n.commit          = 1'b1;
            out_n.commit_misalign = mis;
          end
        end else begin
          out_n.in_ready = 1'b1;
        end
      end
      S_REQ: begin
        // A response seen here is ignored; only the request handshake advances.
        if (mem.req_ready) begin
          state_n         = S_WAIT;
          out_n.req_valid = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem.resp_valid) begin
          state_n        = S_WB;
          out_n.rf_waddr = cur.rd;
          out_n.rf_wdata = cur.is_load ? al_load : cur.result;
          out_n.rf_wen   = cur.rd_wen & cur.is_load & (cur.rd != '0);
          out_n.commit   = 1'b1;
        end
      end
      S_WB: begin
        state_n        = S_IDLE;
        out_n.in_ready = 1'b1;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign in_ready        = out_q.in_ready;
  assign mem.req_valid   = out_q.req_valid;
  assign mem.req_addr    = out_q.req_addr;
  assign mem.req_wen     = out_q.req_wen;
  assign mem.req_wdata   = out_q.req_wdata;
  assign mem.req_wmask   = out_q.req_wmask;
  assign rf_waddr        = out_q.rf_waddr;
  assign rf_wdata        = out_q.rf_wdata;
  assign rf_wen          = out_q.rf_wen;
  assign commit          = out_q.commit;
  assign commit_misalign = out_q.commit_misalign;

endmodule

// File: tb/tb_ysyx_25060170_lsu_wbu.sv
// Scoreboard bench: a reference model predicts memory requests and commits per
// instruction; a monitor compares them against what the stage presents.
module tb_ysyx_25060170_lsu_wbu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic [31:0] in_store_data;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wen;
  logic        commit;
  logic        commit_misalign;

  ysyx_25060170_lsu_wbu_if bus ();

  ysyx_25060170_lsu_wbu #(
    .DATA_W(32), .RADDR_W(5), .CHECK_ALIGN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_result(in_result), .in_store_data(in_store_data),
    .mem(bus),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_wen(rf_wen),
    .commit(commit), .commit_misalign(commit_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wen;
    logic        mis;
  } cmt_t;

  req_t        exp_rq[$];
  cmt_t        exp_cq[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] ram[16];
  logic [31:0] ref_mem[16];
  int          stall_force = 0;
  int          resp_delay_force = -1;
  logic        outstanding = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory slave: random ready, random response latency, occasional stray responses.
  initial begin
    logic        hs;
    int          delay;
    logic [3:0]  hs_idx;
    logic        hs_wen;
    logic [31:0] hs_wdata;
    logic [3:0]  hs_wmask;
    logic [31:0] pend_rdata;
    hs = 1'b0; delay = 0; hs_idx = '0; hs_wen = 1'b0; hs_wdata = '0; hs_wmask = '0; pend_rdata = '0;
    bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_rdata = '0;
    forever begin
      tick();
      bus.resp_valid = 1'b0;
      if (hs) begin
        hs = 1'b0;
        bus.req_ready = 1'b0;
        outstanding = 1'b1;
        delay = (resp_delay_force >= 0) ? resp_delay_force : int'($urandom_range(0, 3));
        resp_delay_force = -1;
        if (hs_wen)
          for (int i = 0; i < 4; i++)
            if (hs_wmask[i]) ram[hs_idx][8*i +: 8] = hs_wdata[8*i +: 8];
        pend_rdata = ram[hs_idx];
      end
      if (outstanding) begin
        if (delay == 0) begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = pend_rdata;
          outstanding = 1'b0;
        end else begin
          delay--;
        end
      end else begin
        if (stall_force > 0 && bus.req_valid) begin
          bus.req_ready = 1'b0;
          stall_force--;
        end else begin
          bus.req_ready = 1'($urandom_range(0, 1));
        end
        hs = bus.req_valid && bus.req_ready && !rst;
        hs_idx = bus.req_addr[5:2]; hs_wen = bus.req_wen;
        hs_wdata = bus.req_wdata; hs_wmask = bus.req_wmask;
        if (!bus.req_ready && $urandom_range(0, 7) == 0) begin
          bus.resp_valid = 1'b1;
          bus.resp_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the stage presents a request or a commit.
  initial begin
    logic req_open;
    req_t held;
    req_t e;
    cmt_t c;
    req_open = 1'b0;
    held = '{default: '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        req_open = 1'b0;
      end else begin
        if (bus.req_valid) begin
          if (!req_open) begin
            check("req_expected", 32'(exp_rq.size() != 0), 32'd1);
            if (exp_rq.size() != 0) begin
              e = exp_rq.pop_front();
              check("req_addr", bus.req_addr, e.addr);
              check("req_wen", 32'(bus.req_wen), 32'(e.wen));
              if (e.wen) begin
                check("req_wdata", bus.req_wdata, e.wdata);
                check("req_wmask", 32'(bus.req_wmask), 32'(e.wmask));
              end
            end
            held = '{addr: bus.req_addr, wen: bus.req_wen, wdata: bus.req_wdata, wmask: bus.req_wmask};
            req_open = 1'b1;
          end else begin
            check("req_hold_addr", bus.req_addr, held.addr);
            check("req_hold_wdata", bus.req_wdata, held.wdata);
            check("req_hold_wmask", 32'(bus.req_wmask), 32'(held.wmask));
          end
          if (bus.req_ready) req_open = 1'b0;
        end
        if (commit || rf_wen) begin
          check("wen_implies_commit", 32'(commit), 32'd1);
          check("commit_expected", 32'(exp_cq.size() != 0), 32'd1);
          if (commit && exp_cq.size() != 0) begin
            c = exp_cq.pop_front();
            check("rf_wen", 32'(rf_wen), 32'(c.wen));
            check("commit_misalign", 32'(commit_misalign), 32'(c.mis));
            if (c.wen) begin
              check("rf_waddr", 32'(rf_waddr), 32'(c.waddr));
              check("rf_wdata", rf_wdata, c.wdata);
            end
          end
        end
      end
    end
  end

  // Reference model: predicts the request and commit of one instruction, then offers it.
  task automatic issue(input logic [4:0] rd, input logic rd_wen, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] res, input logic [31:0] sd);
    int          size;
    int          off;
    int          n;
    int          m;
    logic        mem_op;
    logic        mis;
    logic [3:0]  idx;
    logic [31:0] w;
    logic [31:0] v;
    logic [31:0] lanes;
    req_t        r;
    cmt_t        c;
    n = 0;
    while (!in_ready && n < 300) begin tick(); n++; end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    mem_op = ld | st;
    if (f3 == 3'd0 || (ld && f3 == 3'd4)) size = 1;
    else if (f3 == 3'd1 || (ld && f3 == 3'd5)) size = 2;
    else size = 4;
    off = int'(res[1:0]);
    mis = mem_op && (off % size != 0);
    idx = res[5:2];
    w = ref_mem[idx];
    v = w >> (8 * off);
    if (size == 1) v = (f3 == 3'd4 || !v[7]) ? (v & 32'hFF) : (v | 32'hFFFF_FF00);
    else if (size == 2) v = (f3 == 3'd5 || !v[15]) ? (v & 32'hFFFF) : (v | 32'hFFFF_0000);
    if (mem_op && !mis) begin
      for (int i = 0; i < 4; i++) lanes[8*i +: 8] = sd[8*(i % size) +: 8];
      m = ((1 << size) - 1) << off;
      r = '{addr: res & 32'hFFFF_FFFC, wen: st, wdata: lanes, wmask: m[3:0]};
      exp_rq.push_back(r);
      if (st) for (int i = 0; i < size; i++) ref_mem[idx][8*(off+i) +: 8] = sd[8*i +: 8];
    end
    c = '{waddr: rd, wdata: ld ? v : res, wen: rd_wen && !st && !mis && rd != 0, mis: mis};
    exp_cq.push_back(c);
    in_valid = 1'b1; in_rd = rd; in_rd_wen = rd_wen; in_is_load = ld; in_is_store = st;
    in_funct3 = f3; in_result = res; in_store_data = sd;
    tick();
    in_valid = 1'b0; in_rd = 5'($urandom); in_rd_wen = 1'($urandom); in_is_load = 1'($urandom);
    in_is_store = 1'b0; in_funct3 = 3'($urandom); in_result = $urandom; in_store_data = $urandom;
  endtask

  initial begin
    int n;
    int kind;
    in_valid = 1'b0; in_rd = '0; in_rd_wen = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = '0; in_result = '0; in_store_data = '0;
    for (int i = 0; i < 16; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[0] = 32'h80FF_0011;
    ref_mem[0] = 32'h80FF_0011;

    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_rf_wen", 32'(rf_wen), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_req_addr", bus.req_addr, 32'd0);
    rst = 1'b0;
    tick();

    issue(5'd5, 1'b1, 1'b0, 1'b0, 3'd0, 32'h1234_5678, 32'd0);
    check("alu_commit_next_cycle", 32'(commit), 32'd1);
    check("alu_wdata_next_cycle", rf_wdata, 32'h1234_5678);
    issue(5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'd0);
    issue(5'd8, 1'b1, 1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'd0);
    issue(5'd9, 1'b1, 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hABCD_1234);
    issue(5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 32'h8000_0006, 32'd0);
    check("misalign_no_req", 32'(bus.req_valid), 32'd0);
    check("misalign_commit", 32'(commit_misalign), 32'd1);
    stall_force = 5;
    issue(5'd0, 1'b1, 1'b1, 1'b0, 3'b010, 32'h8000_0010, 32'd0);

    // Reset while waiting for the response; the late response must not write.
    resp_delay_force = 15;
    issue(5'd12, 1'b1, 1'b1, 1'b0, 3'b010, 32'h8000_0020, 32'd0);
    n = 0;
    while (!outstanding && n < 50) begin tick(); n++; end
    check("reached_wait", 32'(outstanding), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_req_valid", 32'(bus.req_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_rf_wen", 32'(rf_wen), 32'd0);
    exp_cq.delete();
    exp_rq.delete();
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int t = 0; t < 250; t++) begin
      kind = int'($urandom_range(0, 2));
      issue(5'($urandom), 1'($urandom), kind == 1, kind == 2, 3'($urandom),
            (kind == 0) ? $urandom : (32'h8000_0000 | 32'($urandom_range(0, 63))), $urandom);
      n = int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) tick();
    end

    n = 0;
    while (exp_cq.size() != 0 && n < 500) begin tick(); n++; end
    check("commit_queue_drained", 32'(exp_cq.size()), 32'd0);
    check("req_queue_drained", 32'(exp_rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
